// File: rtl/button_input_conditioner.sv
// ============================================================================
// button_input_conditioner: synchronises, debounces and edge-detects raw
// button lines and queues the change events for a valid/ready consumer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_input_conditioner #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EVT_DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   button_raw,
  output logic [CHANNELS-1:0]   data_out,
  output logic [CHANNELS-1:0]   rise_pulse,
  output logic [CHANNELS-1:0]   fall_pulse,
  output logic                  event_valid,
  output logic [2*CHANNELS-1:0] event_data,
  input  logic                  event_ready,
  input  logic                  clear_ovf,
  output logic                  overflow
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PTR_W  = $clog2(EVT_DEPTH);
  localparam int unsigned FCNT_W = $clog2(EVT_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(EVT_DEPTH);

  logic [CHANNELS-1:0]   sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]   sync_d [SYNC_STAGES];
  logic [CNT_W-1:0]      cnt_q  [CHANNELS];
  logic [CNT_W-1:0]      cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]   data_q, data_d;
  logic [CHANNELS-1:0]   rise_q, rise_d;
  logic [CHANNELS-1:0]   fall_q, fall_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]     count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [2*CHANNELS-1:0] mem_q [EVT_DEPTH];

  logic [CHANNELS-1:0]   sync_out;
  logic [CHANNELS-1:0]   change;
  logic                  push, pop, full, wr_en;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = button_raw;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Any cycle where the synchronised level agrees with the accepted level
  // restarts qualification, so bounces never accumulate.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_out[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          data_d[i] = sync_out[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    change = data_d ^ data_q;
    rise_d = change & data_d;
    fall_d = change & ~data_d;
    push   = |change;
    full   = (count_q == FIFO_FULL);
    pop    = event_valid && event_ready;
    // A pop frees the head slot on the same edge, so a full FIFO still accepts.
    wr_en  = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = (overflow_q && !clear_ovf) || (push && full && !pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      data_q     <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      data_q     <= data_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {change, data_d};
    end
  end

  assign data_out    = data_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_valid = (count_q != '0);
  assign event_data  = mem_q[rd_ptr_q];
  assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_button_input_conditioner.sv
// ============================================================================
// tb_button_input_conditioner: directed self-checking bench for the
// button input conditioner (2 sync stages, 4-cycle debounce, 4-deep FIFO).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_button_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button_raw;
  logic [3:0] data_out, rise_pulse, fall_pulse;
  logic       event_valid, event_ready, clear_ovf, overflow;
  logic [7:0] event_data;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_prev = 4'h0;

  button_input_conditioner #(
    .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EVT_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .button_raw(button_raw),
    .data_out(data_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_valid(event_valid), .event_data(event_data),
    .event_ready(event_ready), .clear_ovf(clear_ovf), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a new raw level: capture edge is the first step, the level must
  // still be the old one after 5 steps and the new one after the 6th.
  task automatic change(input logic [3:0] raw, input logic [3:0] exp_d,
                        input logic [3:0] exp_r, input logic [3:0] exp_f,
                        input string tag);
    button_raw = raw;
    repeat (5) step();
    check({tag, "_hold"}, 8'(data_out), 8'(exp_prev));
    step();
    check({tag, "_data"}, 8'(data_out), 8'(exp_d));
    check({tag, "_rise"}, 8'(rise_pulse), 8'(exp_r));
    check({tag, "_fall"}, 8'(fall_pulse), 8'(exp_f));
    exp_prev = exp_d;
  endtask

  task automatic pop_expect(input logic [7:0] exp_evt, input string tag);
    check({tag, "_valid"}, 8'(event_valid), 8'h01);
    check({tag, "_evt"}, event_data, exp_evt);
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
  endtask

  initial begin
    int bad;
    reset = 1'b1; button_raw = 4'hF; event_ready = 1'b0; clear_ovf = 1'b0;

    // 1: outputs held at zero during reset, then full qualification of 4'hF
    for (int r = 0; r < 3; r++) begin
      step();
      check("rst_data", 8'(data_out), 8'h00);
      check("rst_pulse", {rise_pulse, fall_pulse}, 8'h00);
      check("rst_valid_ovf", {6'b0, event_valid, overflow}, 8'h00);
    end
    reset = 1'b0;
    change(4'hF, 4'hF, 4'hF, 4'h0, "t1");
    pop_expect(8'hFF, "t1_pop");
    check("t1_rise_1cyc", 8'(rise_pulse), 8'h00);
    check("t1_empty", 8'(event_valid), 8'h00);

    // 2: back to idle, then single channel rise and fall
    change(4'h0, 4'h0, 4'h0, 4'hF, "t2_idle");
    pop_expect(8'hF0, "t2_idle_pop");
    change(4'h1, 4'h1, 4'h1, 4'h0, "t2_rise");
    pop_expect(8'h11, "t2_rise_pop");
    check("t2_pulse_1cyc", {rise_pulse, fall_pulse}, 8'h00);
    change(4'h0, 4'h0, 4'h0, 4'h1, "t2_fall");
    pop_expect(8'h10, "t2_fall_pop");

    // 3: bounce 3 high / 1 low never qualifies
    bad = 0;
    for (int c = 0; c < 24; c++) begin
      button_raw = ((c % 4) != 3) ? 4'h2 : 4'h0;
      step();
      if (data_out != 4'h0 || rise_pulse != 4'h0 || event_valid) bad++;
    end
    check("t3_bounce_quiet", 8'(bad), 8'h00);
    change(4'h2, 4'h2, 4'h2, 4'h0, "t3_hold");
    pop_expect(8'h22, "t3_pop");
    change(4'h0, 4'h0, 4'h0, 4'h2, "t3_release");
    pop_expect(8'h20, "t3_rel_pop");

    // 4: simultaneous rise shares one event; staggered fall gives two
    change(4'hC, 4'hC, 4'hC, 4'h0, "t4_both");
    pop_expect(8'hCC, "t4_both_pop");
    check("t4_one_event", 8'(event_valid), 8'h00);
    button_raw = 4'h8;
    step();
    button_raw = 4'h0;
    repeat (4) step();
    check("t4_hold", 8'(data_out), 8'h0C);
    step();
    check("t4_fall2_data", 8'(data_out), 8'h08);
    check("t4_fall2_pulse", 8'(fall_pulse), 8'h04);
    step();
    check("t4_fall3_data", 8'(data_out), 8'h00);
    check("t4_fall3_pulse", 8'(fall_pulse), 8'h08);
    pop_expect(8'h48, "t4_pop1");
    pop_expect(8'h80, "t4_pop2");
    check("t4_empty", 8'(event_valid), 8'h00);
    exp_prev = 4'h0;

    // 5: fill, overflow, push+pop while full, drain, clear
    change(4'h1, 4'h1, 4'h1, 4'h0, "t5_e1");
    change(4'h3, 4'h3, 4'h2, 4'h0, "t5_e2");
    change(4'h7, 4'h7, 4'h4, 4'h0, "t5_e3");
    change(4'hF, 4'hF, 4'h8, 4'h0, "t5_e4");
    check("t5_full_no_ovf", 8'(overflow), 8'h00);
    change(4'hE, 4'hE, 4'h0, 4'h1, "t5_e5");
    check("t5_ovf", 8'(overflow), 8'h01);
    check("t5_head_stable", event_data, 8'h11);
    button_raw = 4'hC;
    repeat (5) step();
    event_ready = 1'b1;
    step();
    check("t5_e6_data", 8'(data_out), 8'h0C);
    check("t5_e6_fall", 8'(fall_pulse), 8'h02);
    check("t5_pp_head", event_data, 8'h23);
    step();
    check("t5_drain2", event_data, 8'h47);
    step();
    check("t5_drain3", event_data, 8'h8F);
    step();
    check("t5_drain4", event_data, 8'h2C);
    check("t5_drain4_valid", 8'(event_valid), 8'h01);
    step();
    check("t5_drained", 8'(event_valid), 8'h00);
    event_ready = 1'b0;
    check("t5_ovf_sticky", 8'(overflow), 8'h01);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("t5_ovf_clear", 8'(overflow), 8'h00);
    exp_prev = 4'hC;

    // 6: reset mid-qualification with events queued
    change(4'hD, 4'hD, 4'h1, 4'h0, "t6_q1");
    change(4'hF, 4'hF, 4'h2, 4'h0, "t6_q2");
    button_raw = 4'hE;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", 8'(event_valid), 8'h00);
    check("t6_rst_data", 8'(data_out), 8'h00);
    step();
    reset = 1'b0;
    exp_prev = 4'h0;
    change(4'hE, 4'hE, 4'hE, 4'h0, "t6_requal");
    pop_expect(8'hEE, "t6_pop");
    check("t6_empty", 8'(event_valid), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
